if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage RISC-V pipeline: owns the program counter, drives the instruction-memory request/grant/rvalid bus, and holds the PC/ID pipeline register that feeds decode. It consumes the jump, hold and flush controls produced by the pipeline control unit. It discards fetches made stale by a taken jump and buffers one returned instruction while decode is held.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction word presented to decode as a bubble (addi x0,x0,0).

Ports:
- clk_100MHz  input  1  pipeline clock; all state on rising edge.
- arst_n  input  1  asynchronous, active-low reset.
- jump_ena_i  input  1  taken jump/branch from EX this cycle.
- jump_addr_i  input  32 (`MEM_ADDR)  jump target.
- pc_hold_i  input  1  system or hazard hold; freeze PC/ID register.
- pc_id_clr_i  input  1  flush PC/ID register to a bubble.
- ibus_req_o  output  1  fetch request.
- ibus_addr_o  output  32  fetch address; word aligned.
- ibus_gnt_i  input  1  request accepted this cycle.
- ibus_rvalid_i  input  1  read data valid; at least 1 cycle after its gnt.
- ibus_rdata_i  input  32  instruction word.
- id_pc_o  output  32  PC of instruction in decode.
- id_inst_o  output  32  instruction in decode.
- id_valid_o  output  1  decode slot holds a real instruction.
- fetch_busy_o  output  1  request issued and awaiting data.

## Operation
- At most one outstanding request. ibus_addr_o is pc_q. The address may change only while gnt is low.
- FSM states:
  - S_REQ: req=1. On gnt, go to S_WAIT, and pc_q advances by 4 unless a jump occurs the same cycle.
  - S_WAIT: wait for rvalid. When rvalid arrives and the buffer will be free, req=1 in the same cycle (combinational from rvalid), which allows back-to-back fetch. A gnt in that cycle keeps the FSM in S_WAIT; no gnt moves it to S_REQ.
  - S_DROP: discard the next rvalid, then go to S_REQ.
  - S_FULL: buffer occupied and decode held; req=0. When the hold releases, go to S_REQ.
- Jump handling:
  - In S_REQ without gnt: pc_q <= jump_addr_i; stay in S_REQ.
  - In S_REQ with gnt: the granted fetch is stale; go to S_DROP.
  - In S_WAIT without rvalid: go to S_DROP.
  - pc_q <= jump_addr_i in all jump cases.
  - A jump also empties the skid buffer.
- Skid buffer: one entry {pc, inst}. It is filled when rvalid arrives while pc_hold_i=1 and no flush. Decode takes from the buffer before new rvalid data.
- PC/ID register update priority:
  1. pc_id_clr_i → valid=0, inst=NOP_INST.
  2. pc_hold_i → unchanged.
  3. Data available (buffer or non-discarded rvalid) → load it, valid=1.
  4. Otherwise → bubble.
- fetch_busy_o = state is S_WAIT or S_DROP.

## Timing
- Reset values:
  - pc_q=RESET_PC, state=S_REQ, buffer empty.
  - id_valid_o=0, id_inst_o=NOP_INST, id_pc_o=0.
  - ibus_req_o=1 from the first cycle after arst_n rises; it is 0 during reset.
- Zero-wait memory (gnt with req, rvalid next cycle): fetch-to-decode latency is 2 cycles and sustained throughput is 1 instruction per cycle.
- Jump in cycle T: the request for jump_addr_i appears by T+1 if no fetch is in flight, or the cycle after the stale rvalid otherwise. Nothing fetched before T reaches decode after T.
- Reset asserted mid-transaction returns all state immediately. An rvalid that arrives for a pre-reset request is ignored only if seen in S_DROP; the bus must be reset together with this block.
- pc_q wraps 32'hFFFF_FFFC → 0.

## Configuration
- IF_MISALIGN_TRAP_EN defined:
  - Adds output if_misalign_o (1 bit, reset 0).
  - A jump with jump_addr_i[1:0]≠0 sets it sticky and parks the FSM in S_FULL-like idle with req=0.
  - Only the next aligned jump clears it and resumes fetch.
- Not defined: jump_addr_i[1:0] is forced to 2'b00 and no extra port exists.

## Structure
- Shared package/define file: `MEM_ADDR width, instruction width, NOP_INST value, FSM state encodings.
- One natural sub-module, if_skid_buf: the single-entry {pc, inst} buffer with fill/drain/flush.

## Test plan
- Reset release, zero-wait memory: requests at addresses 0, 4, 8 on consecutive cycles; id_pc_o = 0, 4, 8 from cycle 2 with id_valid_o=1.
- rvalid delayed 3 cycles per fetch: req drops while fetch_busy_o=1; bubbles (valid=0, NOP) are inserted between instructions.
- jump_ena_i with target 0x100 while a fetch to 0x8 is in S_WAIT: rdata for 0x8 is never visible in decode; next id_pc_o=0x100.
- pc_hold_i asserted for 4 cycles while rvalid returns 0xC: id_* held, buffer fills, req=0; on release decode shows 0xC next cycle, then 0x10.
- Simultaneous pc_hold_i and pc_id_clr_i with jump: decode becomes a bubble (clear wins) and fetch restarts at the target.
- With IF_MISALIGN_TRAP_EN, jump to 0x102: if_misalign_o=1 and req=0 until a jump to 0x200, after which fetch resumes at 0x200.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// `MEM_ADDR sets the fetch address width and defaults to 32.
`ifndef MEM_ADDR
`define MEM_ADDR 32
`endif

package if_stage_pkg;

    localparam int unsigned ADDR_W = `MEM_ADDR;
    localparam int unsigned INST_W = 32;

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] NOP_INST_WORD = 32'h0000_0013;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_FULL = 2'd3
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry {pc, inst} skid buffer that catches a returned instruction while decode is held.
// A flush has priority over a fill; a simultaneous fill and drain replaces the entry.
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fill_i,
    input  logic              drain_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              valid_next_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q;
    logic [INST_W-1:0] inst_q;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (fill_i) begin
            valid_d = 1'b1;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload carries no reset; it is only observed while valid_q is set.
    always_ff @(posedge clk_i) begin
        if (fill_i && !flush_i) begin
            pc_q   <= pc_i;
            inst_q <= inst_i;
        end
    end

    assign valid_o      = valid_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign valid_next_o = valid_d;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, single-outstanding instruction-bus master, PC/ID register.
// Define IF_MISALIGN_TRAP_EN to trap misaligned jump targets (adds if_misalign_o).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_WORD
) (
    input  logic              clk_100MHz,
    input  logic              arst_n,
    input  logic              jump_ena_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              pc_hold_i,
    input  logic              pc_id_clr_i,
    output logic              ibus_req_o,
    output logic [ADDR_W-1:0] ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [INST_W-1:0] ibus_rdata_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o,
    output logic              fetch_busy_o
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic              if_misalign_o
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] jump_tgt;
    logic              jump_bad;

    logic              req, grant, rv_take, in_flight;
    logic              buf_valid, buf_avail, buf_fill, buf_drain, buf_full_next;
    logic [ADDR_W-1:0] buf_pc;
    logic [INST_W-1:0] buf_inst;

    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;

    assign jump_tgt = word_align(jump_addr_i);

`ifdef IF_MISALIGN_TRAP_EN
    assign jump_bad      = jump_ena_i && (jump_addr_i[1:0] != 2'b00);
    assign if_misalign_o = misalign_q;
`else
    assign jump_bad = 1'b0;
`endif

    // Returned data counts only in S_WAIT, and a same-cycle jump makes it stale.
    assign rv_take   = (state_q == S_WAIT) && ibus_rvalid_i && !jump_ena_i;
    assign buf_avail = buf_valid && !jump_ena_i;
    assign buf_fill  = rv_take && pc_hold_i && !pc_id_clr_i;
    assign buf_drain = buf_avail && !pc_hold_i && !pc_id_clr_i;

    if_skid_buf u_skid (
        .clk_i        (clk_100MHz),
        .rst_ni       (arst_n),
        .fill_i       (buf_fill),
        .drain_i      (buf_drain),
        .flush_i      (jump_ena_i),
        .pc_i         (fetch_pc_q),
        .inst_i       (ibus_rdata_i),
        .valid_o      (buf_valid),
        .pc_o         (buf_pc),
        .inst_o       (buf_inst),
        .valid_next_o (buf_full_next)
    );

    // Back-to-back fetch: in S_WAIT the next request rides on rvalid when nothing will be parked.
    always_comb begin
        req = 1'b0;
        case (state_q)
            S_REQ:   req = 1'b1;
            S_WAIT:  req = rv_take && !buf_full_next;
            default: req = 1'b0;
        endcase
    end

    assign ibus_req_o   = req && arst_n;
    assign ibus_addr_o  = pc_q;
    assign grant        = ibus_req_o && ibus_gnt_i;
    assign fetch_busy_o = (state_q == S_WAIT) || (state_q == S_DROP);
    assign in_flight    = grant ||
                          (((state_q == S_WAIT) || (state_q == S_DROP)) && !ibus_rvalid_i);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;

        if (grant) begin
            pc_d = pc_q + PC_STEP;
        end

        case (state_q)
            S_REQ: begin
                if (grant) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ibus_rvalid_i) begin
                    if (buf_full_next) begin
                        state_d = S_FULL;
                    end else if (grant) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_DROP: begin
                if (ibus_rvalid_i) begin
                    state_d = misalign_q ? S_FULL : S_REQ;
                end
            end
            S_FULL: begin
                if (!buf_full_next && !misalign_q) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Any outstanding fetch is stale after a jump and must be swallowed in S_DROP.
        if (jump_ena_i) begin
            pc_d       = jump_tgt;
            misalign_d = jump_bad;
            if (in_flight) begin
                state_d = S_DROP;
            end else if (jump_bad) begin
                state_d = S_FULL;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        if (pc_id_clr_i) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end else if (!pc_hold_i) begin
            if (buf_avail) begin
                id_valid_d = 1'b1;
                id_pc_d    = buf_pc;
                id_inst_d  = buf_inst;
            end else if (rv_take) begin
                id_valid_d = 1'b1;
                id_pc_d    = fetch_pc_q;
                id_inst_d  = ibus_rdata_i;
            end else begin
                id_valid_d = 1'b0;
                id_inst_d  = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    // Address of the outstanding fetch, paired with its rdata on return.
    always_ff @(posedge clk_100MHz) begin
        if (grant) begin
            fetch_pc_q <= pc_q;
        end
    end

    assign id_valid_o = id_valid_q;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a configurable-latency instruction memory model.
// Define IF_MISALIGN_TRAP_EN for both RTL and bench to cover the misaligned-jump trap.
module tb_if_stage;

    logic        clk_100MHz = 1'b0;
    logic        arst_n = 1'b0;
    logic        jump_ena = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        pc_hold = 1'b0;
    logic        pc_id_clr = 1'b0;
    logic        ibus_req, ibus_gnt, ibus_rvalid;
    logic [31:0] ibus_addr, ibus_rdata;
    logic [31:0] id_pc, id_inst;
    logic        id_valid, fetch_busy;
`ifdef IF_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    logic        gnt_en = 1'b1;
    int unsigned mem_lat = 1;
    logic        pend;
    int unsigned cnt;
    logic [31:0] paddr;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk_100MHz = ~clk_100MHz;

    if_stage dut (
        .clk_100MHz    (clk_100MHz),
        .arst_n        (arst_n),
        .jump_ena_i    (jump_ena),
        .jump_addr_i   (jump_addr),
        .pc_hold_i     (pc_hold),
        .pc_id_clr_i   (pc_id_clr),
        .ibus_req_o    (ibus_req),
        .ibus_addr_o   (ibus_addr),
        .ibus_gnt_i    (ibus_gnt),
        .ibus_rvalid_i (ibus_rvalid),
        .ibus_rdata_i  (ibus_rdata),
        .id_pc_o       (id_pc),
        .id_inst_o     (id_inst),
        .id_valid_o    (id_valid),
        .fetch_busy_o  (fetch_busy)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .if_misalign_o (if_misalign)
`endif
    );

    assign ibus_gnt = ibus_req & gnt_en;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory: rvalid arrives mem_lat cycles after the grant cycle (mem_lat >= 1).
    always @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            pend        <= 1'b0;
            cnt         <= 0;
            paddr       <= '0;
            ibus_rvalid <= 1'b0;
            ibus_rdata  <= '0;
        end else begin
            ibus_rvalid <= 1'b0;
            if (pend) begin
                if (cnt == 1) begin
                    ibus_rvalid <= 1'b1;
                    ibus_rdata  <= inst_of(paddr);
                    pend        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (ibus_req && ibus_gnt) begin
                if (mem_lat <= 1) begin
                    ibus_rvalid <= 1'b1;
                    ibus_rdata  <= inst_of(ibus_addr);
                end else begin
                    pend  <= 1'b1;
                    cnt   <= mem_lat - 1;
                    paddr <= ibus_addr;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, apply controls, let combinational outputs settle.
    task automatic step(input logic j, input logic [31:0] ja, input logic h, input logic c);
        @(negedge clk_100MHz);
        jump_ena  = j;
        jump_addr = ja;
        pc_hold   = h;
        pc_id_clr = c;
        #1;
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst);
        chk({tag, "_valid"}, {31'b0, id_valid}, {31'b0, v});
        if (v) chk({tag, "_pc"}, id_pc, pc);
        chk({tag, "_inst"}, id_inst, inst);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_100MHz);
        #1;
        chk("rst_req", {31'b0, ibus_req}, 32'd0);
        chk("rst_busy", {31'b0, fetch_busy}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk_id("rst", 1'b0, 32'd0, NOP);

        // Zero-wait memory: fetches 0, 4, 8 back to back
        @(negedge clk_100MHz);
        arst_n = 1'b1;
        #1;
        chk("c0_req", {31'b0, ibus_req}, 32'd1);
        chk("c0_addr", ibus_addr, 32'h0);
        step(0, 0, 0, 0);
        chk("c1_addr", ibus_addr, 32'h4);
        chk("c1_id_valid", {31'b0, id_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("c2_addr", ibus_addr, 32'h8);
        chk_id("c2", 1'b1, 32'h0, inst_of(32'h0));
        step(0, 0, 0, 0);
        chk_id("c3", 1'b1, 32'h4, inst_of(32'h4));

        // Hold 4 cycles while 0xC returns
        step(0, 0, 1, 0);
        chk("c4_req", {31'b0, ibus_req}, 32'd0);
        chk_id("c4", 1'b1, 32'h8, inst_of(32'h8));
        for (int i = 5; i <= 7; i++) begin
            step(0, 0, 1, 0);
            chk("hold_req", {31'b0, ibus_req}, 32'd0);
            chk("hold_busy", {31'b0, fetch_busy}, 32'd0);
            chk_id("hold", 1'b1, 32'h8, inst_of(32'h8));
        end
        step(0, 0, 0, 0);
        chk("c8_req", {31'b0, ibus_req}, 32'd0);
        step(0, 0, 0, 0);
        chk_id("c9", 1'b1, 32'hC, inst_of(32'hC));
        chk("c9_addr", ibus_addr, 32'h10);
        chk("c9_req", {31'b0, ibus_req}, 32'd1);
        step(0, 0, 0, 0);
        chk_id("c10", 1'b0, 32'h0, NOP);
        step(0, 0, 0, 0);
        chk_id("c11", 1'b1, 32'h10, inst_of(32'h10));
        chk("c11_addr", ibus_addr, 32'h18);
        mem_lat = 3;

        // Three-cycle memory: request drops while busy, bubbles between instructions
        step(0, 0, 0, 0);
        chk_id("c12", 1'b1, 32'h14, inst_of(32'h14));
        chk("c12_req", {31'b0, ibus_req}, 32'd0);
        chk("c12_busy", {31'b0, fetch_busy}, 32'd1);
        step(0, 0, 0, 0);
        chk_id("c13", 1'b0, 32'h0, NOP);
        step(0, 0, 0, 0);
        chk("c14_req", {31'b0, ibus_req}, 32'd1);
        chk("c14_addr", ibus_addr, 32'h1C);

        // Jump to 0x100 while the fetch to 0x1C is waiting
        step(1, 32'h100, 0, 0);
        chk_id("c15", 1'b1, 32'h18, inst_of(32'h18));
        chk("c15_req", {31'b0, ibus_req}, 32'd0);
        step(0, 0, 0, 0);
        chk("c16_req", {31'b0, ibus_req}, 32'd0);
        chk("c16_busy", {31'b0, fetch_busy}, 32'd1);
        chk_id("c16", 1'b0, 32'h0, NOP);
        step(0, 0, 0, 0);
        chk("c17_rvalid", {31'b0, ibus_rvalid}, 32'd1);
        chk("c17_req", {31'b0, ibus_req}, 32'd0);
        step(0, 0, 0, 0);
        chk("c18_req", {31'b0, ibus_req}, 32'd1);
        chk("c18_addr", ibus_addr, 32'h100);
        chk_id("c18", 1'b0, 32'h0, NOP);
        mem_lat = 1;
        step(0, 0, 0, 0);
        chk_id("c19", 1'b0, 32'h0, NOP);
        step(1, 32'h200, 1, 1);
        chk("c20_req", {31'b0, ibus_req}, 32'd0);
        chk_id("c20", 1'b1, 32'h100, inst_of(32'h100));

        // Hold + clear + jump together: clear wins, fetch restarts at 0x200
        step(0, 0, 0, 0);
        chk_id("c21", 1'b0, 32'h0, NOP);
        chk("c21_addr", ibus_addr, 32'h200);
        chk("c21_req", {31'b0, ibus_req}, 32'd1);
        step(0, 0, 0, 0);
        chk("c22_addr", ibus_addr, 32'h204);
        step(1, 32'hFFFF_FFFC, 0, 0);
        chk_id("c23", 1'b1, 32'h200, inst_of(32'h200));

        // PC wrap from 0xFFFF_FFFC to 0
        step(0, 0, 0, 0);
        chk("c24_addr", ibus_addr, 32'hFFFF_FFFC);
        chk_id("c24", 1'b0, 32'h0, NOP);
        step(0, 0, 0, 0);
        chk("c25_addr", ibus_addr, 32'h0);
        step(0, 0, 0, 0);
        chk_id("c26", 1'b1, 32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC));

        // Reset mid-transaction
        arst_n = 1'b0;
        #1;
        chk("mrst_req", {31'b0, ibus_req}, 32'd0);
        chk("mrst_busy", {31'b0, fetch_busy}, 32'd0);
        chk("mrst_addr", ibus_addr, 32'h0);
        chk("mrst_id_pc", id_pc, 32'h0);
        chk_id("mrst", 1'b0, 32'h0, NOP);

        // Release and jump to misaligned 0x102 while fetch to 0 is granted
        @(negedge clk_100MHz);
        arst_n    = 1'b1;
        jump_ena  = 1'b1;
        jump_addr = 32'h102;
        #1;
        chk("r0_req", {31'b0, ibus_req}, 32'd1);
        chk("r0_addr", ibus_addr, 32'h0);
        step(0, 0, 0, 0);
        chk("r1_req", {31'b0, ibus_req}, 32'd0);
        chk("r1_busy", {31'b0, fetch_busy}, 32'd1);
`ifdef IF_MISALIGN_TRAP_EN
        chk("r1_misalign", {31'b0, if_misalign}, 32'd1);
`endif
        step(0, 0, 0, 0);
`ifdef IF_MISALIGN_TRAP_EN
        chk("r2_req", {31'b0, ibus_req}, 32'd0);
        chk("r2_misalign", {31'b0, if_misalign}, 32'd1);
        chk("r2_busy", {31'b0, fetch_busy}, 32'd0);
`else
        chk("r2_req", {31'b0, ibus_req}, 32'd1);
        chk("r2_addr", ibus_addr, 32'h100);
`endif
        step(1, 32'h200, 0, 0);
        chk("r3_req", {31'b0, ibus_req}, 32'd0);
        step(0, 0, 0, 0);
        chk("r4_req", {31'b0, ibus_req}, 32'd1);
        chk("r4_addr", ibus_addr, 32'h200);
        chk_id("r4", 1'b0, 32'h0, NOP);
`ifdef IF_MISALIGN_TRAP_EN
        chk("r4_misalign", {31'b0, if_misalign}, 32'd0);
`endif
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_id("r6", 1'b1, 32'h200, inst_of(32'h200));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
